router_src_tx: RTL and testbench
================================

Name: router_src_tx

Overview:
- Packet transmitter for the source port of the 1x3 router; it drives pkt_valid/data_in and obeys busy/err.
- Accepts a packet request and its payload bytes from an upstream stream and buffers the whole payload.
- Emits header, payload and a computed parity byte, honouring busy stalls.
- Reports per-packet status from the router's err response. Sits between the traffic generator and the router source port.

Parameters:
- MAX_LEN, 63: maximum payload bytes; sets buffer depth to MAX_LEN+1.
- ERR_WIN, 4: cycles err is sampled after the parity byte is accepted.
- IPG, 2: idle cycles after status before the next request (minimum 1).
- CNT_W, 16: width of pkt_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  packet request valid.
- req_ready  out  1  request accepted when high with req_valid.
- req_addr  in  2  destination port 0..2.
- req_len  in  6  payload length 1..63.
- pl_valid  in  1  payload byte valid.
- pl_ready  out  1  payload byte accepted when high with pl_valid.
- pl_data  in  8  payload byte.
- pkt_valid  out  1  to router; high for header and payload, low for parity.
- data_in  out  8  to router; current byte.
- busy  in  1  router stall; a byte is consumed at a rising edge only when busy is sampled low.
- err  in  1  router parity-error indication.
- done  out  1  one-cycle pulse when status is valid.
- status  out  2  00 OK, 01 router err, 10 bad request; held until the next done.
- pkt_cnt  out  CNT_W  OK packets sent; wraps.
- err_cnt  out  8  status-01 packets; saturates at 255.

Behaviour:
- Reset (rst low, asynchronous): all outputs are 0 except req_ready, which is 0 in reset and 1 in the first cycle after release. State goes to IDLE; parity, pointers and counters clear. A reset mid-packet drops pkt_valid immediately; recovery of the truncated packet is the router's concern.
- FSM states: IDLE, LOAD, HDR, PAYLOAD, PARITY, ERRCHK, GAP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr and len.
  - If addr==2'b11 or len==0: go to GAP, with done=1 and status=10 in the next cycle. No router activity.
  - Else go to LOAD.
- LOAD:
  - pl_ready=1.
  - Each pl_valid&pl_ready writes the byte to the buffer at wr_ptr and XORs it into parity.
  - Gaps in pl_valid are allowed.
  - After byte len is accepted, go to HDR.
- HDR:
  - Registered outputs: pkt_valid=1, data_in={len,addr}; parity ^= header.
  - The byte is held stable while busy=1.
  - On a rising edge with busy=0, go to PAYLOAD with rd_ptr=0.
- PAYLOAD:
  - pkt_valid=1, data_in=buf[rd_ptr].
  - Advance on busy=0.
  - After the last byte, go to PARITY.
- PARITY:
  - pkt_valid=0, data_in=parity.
  - Held while busy=1; on busy=0 go to ERRCHK.
- ERRCHK:
  - data_in=0, pkt_valid=0.
  - Sample err for ERR_WIN cycles; any high sets err_seen.
  - At window end: done=1; status=01 if err_seen else 00.
  - pkt_cnt increments on 00; err_cnt saturating-increments on 01.
  - Go to GAP.
- GAP: IPG cycles with pkt_valid=0 and req_ready=0, then IDLE.
- Outputs:
  - req_ready=1 only in IDLE; pl_ready=1 only in LOAD.
  - pkt_valid and data_in are registered and never glitch.
- Timing and ordering:
  - With busy=0, the header appears 1 cycle after the last payload byte is accepted.
  - Payload bytes and parity follow on consecutive cycles.
  - A pl handshake and a busy edge never coincide, because the phases are disjoint.
  - No timeout on busy: stalls persist indefinitely.

Decomposition:
- Package router_pkg holds:
  - the state enum and status codes (ST_OK, ST_RERR, ST_BADREQ);
  - the invalid-address constant 2'b11;
  - a header-pack function {len,addr}.
- Sub-module router_tx_buf: simple dual-port buffer, (MAX_LEN+1)x8, with write and read pointers.

Test Plan:
1. Basic packet, busy held 0:
   - Stimulus: addr=01, len=3, payload A1 B2 C3.
   - data_in shows 0D, A1, B2, C3 with pkt_valid=1, then DD with pkt_valid=0.
   - done after 4 ERRCHK cycles with status=00; pkt_cnt=1.
2. Busy stall: busy=1 for 3 cycles during the header.
   - 0D is held for 4 cycles.
   - The rest of the sequence and parity DD are unchanged; no byte is skipped or duplicated.
3. Router error: err pulses 2 cycles after parity is accepted.
   - status=01, err_cnt=1, pkt_cnt unchanged.
4. Bad requests:
   - req_addr=11 gives status=10; pl_ready never asserts and pkt_valid stays 0.
   - Same for req_len=0.
5. Maximum length: addr=10, len=63, random pl_valid gaps.
   - Header is FE; 63 bytes follow in order.
   - Parity equals FE XOR all bytes; status=00.
6. Reset mid-packet: rst low during PAYLOAD.
   - pkt_valid and data_in go 0 asynchronously.
   - After release req_ready=1 and the next packet (addr=00, len=1, byte 55) yields 04, 55, 51.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and helpers for the router source-port transmitter.
package router_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_HDR     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PARITY  = 3'd4;
  localparam logic [2:0] S_ERRCHK  = 3'd5;
  localparam logic [2:0] S_GAP     = 3'd6;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_RERR   = 2'b01;
  localparam logic [1:0] ST_BADREQ = 2'b10;

  localparam logic [1:0] ADDR_INVALID = 2'b11;

  function automatic logic [7:0] hdr_pack(input logic [5:0] len, input logic [1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: one write port, one registered read port.
module router_tx_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data_q;

  // Write-first forwarding so a byte written on the last LOAD edge is
  // already visible when the header cycle hands over to the payload.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data_q <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/router_src_tx.sv
// Source-port packet transmitter: buffers a payload, then sends header,
// payload and parity to the router and reports the router's err response.
module router_src_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63,
  parameter int ERR_WIN = 4,
  parameter int IPG     = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_addr,
  input  logic [5:0]       req_len,
  input  logic             pl_valid,
  output logic             pl_ready,
  input  logic [7:0]       pl_data,
  output logic             pkt_valid,
  output logic [7:0]       data_in,
  input  logic             busy,
  input  logic             err,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [7:0]       err_cnt
);

  localparam int WIN_W = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;
  localparam int GAP_W = (IPG > 1) ? $clog2(IPG) : 1;

  logic [2:0]       state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic [5:0]       len_q, len_d;
  logic [5:0]       wr_ptr_q, wr_ptr_d;
  logic [5:0]       rd_ptr_q, rd_ptr_d;
  logic [7:0]       parity_q, parity_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             err_seen_q, err_seen_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic [7:0]       data_in_q, data_in_d;
  logic             done_q, done_d;
  logic [1:0]       status_q, status_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             pl_ready_q, pl_ready_d;
  logic             buf_we;
  logic [7:0]       buf_rd_data;

  router_tx_buf #(.DEPTH(MAX_LEN + 1), .AW(6)) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (wr_ptr_q),
    .wr_data (pl_data),
    .rd_addr (rd_ptr_d),
    .rd_data (buf_rd_data)
  );

  // rd_ptr counts payload bytes already loaded into data_in; the buffer is
  // read one cycle ahead at rd_ptr_d so buf_rd_data is the next byte.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    parity_d    = parity_q;
    win_d       = win_q;
    err_seen_d  = err_seen_q;
    gap_d       = gap_q;
    pkt_valid_d = pkt_valid_q;
    data_in_d   = data_in_q;
    done_d      = 1'b0;
    status_d    = status_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    buf_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d = req_addr;
          len_d  = req_len;
          if (req_addr == ADDR_INVALID || req_len == 6'd0) begin
            state_d  = S_GAP;
            gap_d    = '0;
            done_d   = 1'b1;
            status_d = ST_BADREQ;
          end else begin
            state_d  = S_LOAD;
            wr_ptr_d = 6'd0;
            rd_ptr_d = 6'd0;
            parity_d = 8'h00;
          end
        end
      end
      S_LOAD: begin
        if (pl_valid && pl_ready_q) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 6'd1;
          parity_d = parity_q ^ pl_data;
          if (wr_ptr_q == len_q - 6'd1) begin
            state_d     = S_HDR;
            pkt_valid_d = 1'b1;
            data_in_d   = hdr_pack(len_q, addr_q);
            parity_d    = parity_q ^ pl_data ^ hdr_pack(len_q, addr_q);
          end
        end
      end
      S_HDR: begin
        if (!busy) begin
          state_d   = S_PAYLOAD;
          data_in_d = buf_rd_data;
          rd_ptr_d  = 6'd1;
        end
      end
      S_PAYLOAD: begin
        if (!busy) begin
          if (rd_ptr_q == len_q) begin
            state_d     = S_PARITY;
            pkt_valid_d = 1'b0;
            data_in_d   = parity_q;
          end else begin
            data_in_d = buf_rd_data;
            rd_ptr_d  = rd_ptr_q + 6'd1;
          end
        end
      end
      S_PARITY: begin
        if (!busy) begin
          state_d    = S_ERRCHK;
          data_in_d  = 8'h00;
          win_d      = '0;
          err_seen_d = 1'b0;
        end
      end
      S_ERRCHK: begin
        err_seen_d = err_seen_q | err;
        win_d      = win_q + 1'b1;
        if (win_q == WIN_W'(ERR_WIN - 1)) begin
          state_d = S_GAP;
          gap_d   = '0;
          done_d  = 1'b1;
          if (err_seen_q || err) begin
            status_d = ST_RERR;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            status_d  = ST_OK;
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_W'(IPG - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    pl_ready_d  = (state_d == S_LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      addr_q      <= 2'b00;
      len_q       <= 6'd0;
      wr_ptr_q    <= 6'd0;
      rd_ptr_q    <= 6'd0;
      parity_q    <= 8'h00;
      win_q       <= '0;
      err_seen_q  <= 1'b0;
      gap_q       <= '0;
      pkt_valid_q <= 1'b0;
      data_in_q   <= 8'h00;
      done_q      <= 1'b0;
      status_q    <= ST_OK;
      pkt_cnt_q   <= '0;
      err_cnt_q   <= 8'h00;
      req_ready_q <= 1'b0;
      pl_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      parity_q    <= parity_d;
      win_q       <= win_d;
      err_seen_q  <= err_seen_d;
      gap_q       <= gap_d;
      pkt_valid_q <= pkt_valid_d;
      data_in_q   <= data_in_d;
      done_q      <= done_d;
      status_q    <= status_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
      req_ready_q <= req_ready_d;
      pl_ready_q  <= pl_ready_d;
    end
  end

  assign req_ready = req_ready_q;
  assign pl_ready  = pl_ready_q;
  assign pkt_valid = pkt_valid_q;
  assign data_in   = data_in_q;
  assign done      = done_q;
  assign status    = status_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_router_src_tx.sv
// Scoreboard bench for router_src_tx: expected router bytes and statuses are
// queued at stimulus time and popped as the router side consumes them.
module tb_router_src_tx;
  import router_pkg::*;

  localparam int ERR_WIN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_addr = 2'b00;
  logic [5:0]  req_len = 6'd0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [7:0]  pl_data = 8'h00;
  logic        pkt_valid;
  logic [7:0]  data_in;
  logic        busy = 1'b0;
  logic        err = 1'b0;
  logic        done;
  logic [1:0]  status;
  logic [15:0] pkt_cnt;
  logic [7:0]  err_cnt;

  router_src_tx #(.MAX_LEN(63), .ERR_WIN(ERR_WIN), .IPG(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .pkt_valid (pkt_valid),
    .data_in   (data_in),
    .busy      (busy),
    .err       (err),
    .done      (done),
    .status    (status),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [8:0]  exp_bytes [$];
  logic [1:0]  exp_status [$];
  logic [7:0]  pl_mem [64];
  int          cyc = 0;
  int          par_cyc = 0;
  int          par_cnt = 0;
  int          byte_cnt = 0;
  bit          in_pkt = 1'b0;
  bit          quiet = 1'b0;
  bit          quiet_viol = 1'b0;
  logic [15:0] exp_pkt_cnt = '0;
  logic [7:0]  exp_err_cnt = '0;
  logic [8:0]  mon_e;
  logic [1:0]  mon_s;

  // Router-side monitor: a byte is consumed when busy is low at the next edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (quiet) quiet_viol = quiet_viol | pl_ready | pkt_valid;
      if (!busy && (pkt_valid || in_pkt)) begin
        byte_cnt++;
        if (exp_bytes.size() == 0) begin
          check("byte_unexpected", 32'(exp_bytes.size()), 32'd1);
        end else begin
          mon_e = exp_bytes.pop_front();
          check("byte", 32'({pkt_valid, data_in}), 32'(mon_e));
          $display("byte pv=%0b data=%02h", pkt_valid, data_in);
        end
        if (pkt_valid) in_pkt = 1'b1;
        else begin
          in_pkt  = 1'b0;
          par_cnt++;
          par_cyc = cyc;
        end
      end
      if (done) begin
        if (exp_status.size() == 0) begin
          check("done_unexpected", 32'(exp_status.size()), 32'd1);
        end else begin
          mon_s = exp_status.pop_front();
          check("status", 32'(status), 32'(mon_s));
          if (mon_s == ST_OK) exp_pkt_cnt = exp_pkt_cnt + 16'd1;
          if (mon_s == ST_RERR && exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
          check("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt_cnt));
          check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
          if (mon_s != ST_BADREQ) check("done_latency", 32'(cyc - par_cyc), 32'(ERR_WIN + 1));
          $display("done status=%02b pkt_cnt=%0d err_cnt=%0d", status, pkt_cnt, err_cnt);
        end
      end
    end
  end

  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input bit gaps,
                          input logic [1:0] exp_st);
    int n;
    logic ok;
    logic [7:0] h, p;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (a == 2'b11 || l == 6'd0) begin
      exp_status.push_back(ST_BADREQ);
      return;
    end
    h = {l, a};
    p = h;
    exp_bytes.push_back({1'b1, h});
    for (int i = 0; i < int'(l); i++) begin
      p = p ^ pl_mem[i];
      exp_bytes.push_back({1'b1, pl_mem[i]});
    end
    exp_bytes.push_back({1'b0, p});
    exp_status.push_back(exp_st);
    for (int i = 0; i < int'(l); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          pl_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      pl_valid = 1'b1;
      pl_data  = pl_mem[i];
      n = 0;
      do begin
        ok = pl_ready;
        @(posedge clk); #1;
        n++;
      end while (!ok && n < 200);
      if (!ok) begin
        check("pl_ready_timeout", 32'(ok), 32'd1);
        pl_valid = 1'b0;
        return;
      end
    end
    pl_valid = 1'b0;
    check("hdr_valid", 32'(pkt_valid), 32'd1);
    check("hdr_data", 32'(data_in), 32'(h));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_status.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(exp_bytes.size() + exp_status.size()), 32'd0);
  endtask

  task automatic inject_err();
    int p0, n;
    p0 = par_cnt;
    n = 0;
    while (par_cnt == p0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (par_cnt == p0) begin
      check("err_inject_timeout", 32'(par_cnt), 32'(p0 + 1));
      return;
    end
    #1;
    @(posedge clk); #1;
    err = 1'b1;
    @(posedge clk); #1;
    err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_pl_ready", 32'(pl_ready), 32'd0);
    check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check("rst_data_in", 32'(data_in), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("req_ready_after_rst", 32'(req_ready), 32'd1);

    // basic packet
    pl_mem[0] = 8'hA1; pl_mem[1] = 8'hB2; pl_mem[2] = 8'hC3;
    send_pkt(2'b01, 6'd3, 1'b0, ST_OK);
    wait_idle();

    // header stall
    busy = 1'b1;
    send_pkt(2'b01, 6'd3, 1'b0, ST_OK);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("stall_hold_data", 32'(data_in), 32'h0D);
      check("stall_hold_valid", 32'(pkt_valid), 32'd1);
    end
    busy = 1'b0;
    wait_idle();

    // router error
    fork
      send_pkt(2'b01, 6'd3, 1'b0, ST_RERR);
      inject_err();
    join
    wait_idle();

    // bad requests
    quiet = 1'b1;
    send_pkt(2'b11, 6'd5, 1'b0, ST_BADREQ);
    wait_idle();
    send_pkt(2'b01, 6'd0, 1'b0, ST_BADREQ);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    quiet = 1'b0;
    check("badreq_quiet", 32'(quiet_viol), 32'd0);

    // maximum length with payload gaps
    for (int i = 0; i < 63; i++) pl_mem[i] = 8'($urandom_range(0, 255));
    send_pkt(2'b10, 6'd63, 1'b1, ST_OK);
    wait_idle();

    // reset in the middle of the payload
    for (int i = 0; i < 5; i++) pl_mem[i] = 8'(8'h10 + i);
    b0 = byte_cnt;
    send_pkt(2'b01, 6'd5, 1'b0, ST_OK);
    n = 0;
    while (byte_cnt < b0 + 3 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("reached_payload", 32'(byte_cnt >= b0 + 3), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("async_pkt_valid", 32'(pkt_valid), 32'd0);
    check("async_data_in", 32'(data_in), 32'd0);
    check("async_req_ready", 32'(req_ready), 32'd0);
    exp_bytes.delete();
    exp_status.delete();
    in_pkt = 1'b0;
    exp_pkt_cnt = '0;
    exp_err_cnt = '0;
    check("async_pkt_cnt", 32'(pkt_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check("req_ready_after_rst2", 32'(req_ready), 32'd1);
    pl_mem[0] = 8'h55;
    send_pkt(2'b00, 6'd1, 1'b0, ST_OK);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
